// File: rtl/timer_pkg.sv
`default_nettype none
// ---------------------------------------------------------------------------
// timer_pkg: register offsets, TCR/TSR bit positions and clock-select codes.
// Revision: 1.0
// ---------------------------------------------------------------------------
package timer_pkg;

  localparam logic [1:0] TCR_A  = 2'd0;
  localparam logic [1:0] TDR_A  = 2'd1;
  localparam logic [1:0] TCNT_A = 2'd2;
  localparam logic [1:0] TSR_A  = 2'd3;

  localparam int TCR_LOAD = 7;
  localparam int TCR_AR   = 6;
  localparam int TCR_DOWN = 5;
  localparam int TCR_EN   = 4;
  localparam int TCR_IE   = 2;

  localparam int TSR_OVF = 0;
  localparam int TSR_UDF = 1;

  typedef enum logic [1:0] {
    CLK_DIV2  = 2'd0,
    CLK_DIV4  = 2'd1,
    CLK_DIV8  = 2'd2,
    CLK_DIV16 = 2'd3
  } clksel_e;

endpackage
`default_nettype wire

// File: rtl/timer_channel.sv
`default_nettype none
// ---------------------------------------------------------------------------
// timer_channel: one up/down counter with its TCR, TDR and sticky TSR.
// Revision: 1.0
// ---------------------------------------------------------------------------
module timer_channel
  import timer_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic             pclk,
  input  logic             preset,
  input  logic [3:0]       tick,
  input  logic             wr_tcr,
  input  logic             wr_tdr,
  input  logic             wr_tsr,
  input  logic [WIDTH-1:0] wdata,
  output logic [7:0]       tcr,
  output logic [WIDTH-1:0] tdr,
  output logic [WIDTH-1:0] cnt,
  output logic             ovf,
  output logic             udf,
  output logic             ie
);

  logic             auto_rld;
  logic             down;
  logic             en;
  clksel_e          clksel;
  logic [WIDTH-1:0] cnt_next;
  logic             load;
  logic             count;
  logic             at_max;
  logic             at_min;
  logic             set_ovf;
  logic             set_udf;

  assign tcr     = {1'b0, auto_rld, down, en, 1'b0, ie, clksel};
  assign load    = wr_tcr & wdata[TCR_LOAD];
  assign count   = en & tick[clksel] & ~load;
  assign at_max  = (cnt == '1);
  assign at_min  = (cnt == '0);
  assign set_ovf = count & ~down & at_max;
  assign set_udf = count & down & at_min;

  always_comb begin
    cnt_next = cnt;
    if (load) begin
      cnt_next = tdr;
    end else if (count) begin
      if (down) begin
        cnt_next = at_min ? (auto_rld ? tdr : '1) : cnt - WIDTH'(1);
      end else begin
        cnt_next = at_max ? (auto_rld ? tdr : '0) : cnt + WIDTH'(1);
      end
    end
  end

  // A flag being set outranks a W1C of the same bit at the same edge.
  always_ff @(posedge pclk) begin
    if (preset) begin
      cnt      <= '0;
      tdr      <= '0;
      auto_rld <= 1'b0;
      down     <= 1'b0;
      en       <= 1'b0;
      ie       <= 1'b0;
      clksel   <= CLK_DIV2;
      ovf      <= 1'b0;
      udf      <= 1'b0;
    end else begin
      cnt <= cnt_next;
      if (wr_tcr) begin
        auto_rld <= wdata[TCR_AR];
        down     <= wdata[TCR_DOWN];
        en       <= wdata[TCR_EN];
        ie       <= wdata[TCR_IE];
        clksel   <= clksel_e'(wdata[1:0]);
      end
      if (wr_tdr) begin
        tdr <= wdata;
      end
      ovf <= (ovf & ~(wr_tsr & wdata[TSR_OVF])) | set_ovf;
      udf <= (udf & ~(wr_tsr & wdata[TSR_UDF])) | set_udf;
    end
  end

endmodule
`default_nettype wire

// File: rtl/timer_counter_multi.sv
`default_nettype none
// ---------------------------------------------------------------------------
// timer_counter_multi: APB-mapped multi-channel timer with shared prescaler.
// Revision: 1.0
// ---------------------------------------------------------------------------
module timer_counter_multi
  import timer_pkg::*;
#(
  parameter int WIDTH      = 8,
  parameter int CHANNELS   = 2,
  parameter int ADDR_WIDTH = 2 + ((CHANNELS > 1) ? $clog2(CHANNELS) : 1)
) (
  input  logic                  pclk,
  input  logic                  preset,
  input  logic                  psel,
  input  logic                  penable,
  input  logic                  pwrite,
  input  logic [ADDR_WIDTH-1:0] paddr,
  input  logic [WIDTH-1:0]      pwdata,
  output logic [WIDTH-1:0]      prdata,
  output logic                  pready,
  output logic                  pslverr,
  output logic [CHANNELS-1:0]   tmr_ovf,
  output logic [CHANNELS-1:0]   tmr_udf,
  output logic                  irq
);

  localparam int CW = ADDR_WIDTH - 2;

  logic [3:0]                          presc;
  logic [3:0]                          tick;
  logic                                access;
  logic [CW-1:0]                       ch;
  logic [1:0]                          rsel;
  logic                                ch_valid;
  logic                                err;
  logic                                wr_ok;
  logic [CHANNELS-1:0]                 ch_sel;
  logic [CHANNELS-1:0][7:0]            tcr_a;
  logic [CHANNELS-1:0][WIDTH-1:0]      tdr_a;
  logic [CHANNELS-1:0][WIDTH-1:0]      cnt_a;
  logic [CHANNELS-1:0]                 ie_a;

  // Free-running; channel enables never gate it, so tick phase survives pauses.
  always_ff @(posedge pclk) begin
    if (preset) begin
      presc <= '0;
    end else begin
      presc <= presc + 4'd1;
    end
  end

  assign tick = {&presc[3:0], &presc[2:0], &presc[1:0], presc[0]};

  assign access   = psel & penable;
  assign ch       = paddr[ADDR_WIDTH-1:2];
  assign rsel     = paddr[1:0];
  assign ch_valid = (int'(ch) < CHANNELS);
  assign err      = access & (~ch_valid | (pwrite & (rsel == TCNT_A)));
  assign wr_ok    = access & pwrite & ~err;
  assign pready   = access;
  assign pslverr  = err;

  always_comb begin
    ch_sel = '0;
    for (int i = 0; i < CHANNELS; i++) begin
      ch_sel[i] = (int'(ch) == i);
    end
  end

  generate
    for (genvar i = 0; i < CHANNELS; i++) begin : g_ch
      timer_channel #(
        .WIDTH(WIDTH)
      ) u_chan (
        .pclk   (pclk),
        .preset (preset),
        .tick   (tick),
        .wr_tcr (wr_ok & ch_sel[i] & (rsel == TCR_A)),
        .wr_tdr (wr_ok & ch_sel[i] & (rsel == TDR_A)),
        .wr_tsr (wr_ok & ch_sel[i] & (rsel == TSR_A)),
        .wdata  (pwdata),
        .tcr    (tcr_a[i]),
        .tdr    (tdr_a[i]),
        .cnt    (cnt_a[i]),
        .ovf    (tmr_ovf[i]),
        .udf    (tmr_udf[i]),
        .ie     (ie_a[i])
      );
    end
  endgenerate

  always_comb begin
    prdata = '0;
    if (access & ~pwrite & ~err) begin
      for (int i = 0; i < CHANNELS; i++) begin
        if (ch_sel[i]) begin
          case (rsel)
            TCR_A:   prdata = WIDTH'(tcr_a[i]);
            TDR_A:   prdata = tdr_a[i];
            TCNT_A:  prdata = cnt_a[i];
            default: prdata = WIDTH'({tmr_udf[i], tmr_ovf[i]});
          endcase
        end
      end
    end
  end

  assign irq = |((tmr_ovf | tmr_udf) & ie_a);

endmodule
`default_nettype wire

// File: tb/tb_timer_counter_multi.sv
`default_nettype none
// ---------------------------------------------------------------------------
// tb_timer_counter_multi: directed + random APB traffic against a cycle model.
// Revision: 1.0
// ---------------------------------------------------------------------------
module tb_timer_counter_multi;

  localparam int W   = 8;
  localparam int C   = 2;
  localparam int AW  = 4;
  localparam int MAX = (1 << W) - 1;

  logic          pclk = 1'b0;
  logic          preset;
  logic          psel;
  logic          penable;
  logic          pwrite;
  logic [AW-1:0] paddr;
  logic [W-1:0]  pwdata;
  logic [W-1:0]  prdata;
  logic          pready;
  logic          pslverr;
  logic [C-1:0]  tmr_ovf;
  logic [C-1:0]  tmr_udf;
  logic          irq;

  int compared   = 0;
  int mismatched = 0;

  // Model state: plain integers per channel, plus edges elapsed since reset.
  int m_cnt[C];
  int m_tdr[C];
  int m_cs[C];
  bit m_ar[C];
  bit m_dn[C];
  bit m_en[C];
  bit m_ie[C];
  bit m_ovf[C];
  bit m_udf[C];
  int n_edges;

  timer_counter_multi #(
    .WIDTH(W), .CHANNELS(C), .ADDR_WIDTH(AW)
  ) dut (
    .pclk(pclk), .preset(preset), .psel(psel), .penable(penable),
    .pwrite(pwrite), .paddr(paddr), .pwdata(pwdata), .prdata(prdata),
    .pready(pready), .pslverr(pslverr), .tmr_ovf(tmr_ovf),
    .tmr_udf(tmr_udf), .irq(irq)
  );

  always #5 pclk = ~pclk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    compared++;
    assert (obs === exp) else begin
      mismatched++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic int mread(input int ch, input int rg);
    if (ch >= C) return 0;
    case (rg)
      0:       return (int'(m_ar[ch]) << 6) | (int'(m_dn[ch]) << 5) |
                      (int'(m_en[ch]) << 4) | (int'(m_ie[ch]) << 2) | m_cs[ch];
      1:       return m_tdr[ch];
      2:       return m_cnt[ch];
      default: return (int'(m_udf[ch]) << 1) | int'(m_ovf[ch]);
    endcase
  endfunction

  function automatic bit m_irq();
    bit r = 0;
    for (int i = 0; i < C; i++) r |= (m_ovf[i] | m_udf[i]) & m_ie[i];
    return r;
  endfunction

  // One clock: evaluate the spec rules on the current inputs, take the edge,
  // commit the model and compare the flag outputs.
  task automatic step();
    int  ncnt[C];
    int  ntdr[C];
    int  ncs[C];
    bit  nar[C];
    bit  ndn[C];
    bit  nen[C];
    bit  nie[C];
    bit  novf[C];
    bit  nudf[C];
    bit  acc;
    bit  wok;
    bit  rst;
    int  ch;
    int  rg;
    #1;
    acc = psel && penable;
    if (!acc) begin
      chk("idle_prdata", prdata, 0);
      chk("idle_pready", pready, 0);
      chk("idle_pslverr", pslverr, 0);
    end
    ch  = int'(paddr[AW-1:2]);
    rg  = int'(paddr[1:0]);
    wok = acc && pwrite && (ch < C) && (rg != 2);
    rst = preset;
    for (int i = 0; i < C; i++) begin
      int per;
      bit tk;
      bit w;
      bit so;
      bit su;
      ncnt[i] = m_cnt[i]; ntdr[i] = m_tdr[i]; ncs[i] = m_cs[i];
      nar[i] = m_ar[i]; ndn[i] = m_dn[i]; nen[i] = m_en[i]; nie[i] = m_ie[i];
      per = 2 << m_cs[i];
      tk  = (n_edges % per) == (per - 1);
      w   = wok && (ch == i);
      so  = 0;
      su  = 0;
      if (w && rg == 0 && pwdata[7]) begin
        ncnt[i] = m_tdr[i];
      end else if (m_en[i] && tk) begin
        if (!m_dn[i]) begin
          if (m_cnt[i] == MAX) begin ncnt[i] = m_ar[i] ? m_tdr[i] : 0; so = 1; end
          else ncnt[i] = m_cnt[i] + 1;
        end else begin
          if (m_cnt[i] == 0) begin ncnt[i] = m_ar[i] ? m_tdr[i] : MAX; su = 1; end
          else ncnt[i] = m_cnt[i] - 1;
        end
      end
      if (w && rg == 0) begin
        nar[i] = pwdata[6]; ndn[i] = pwdata[5]; nen[i] = pwdata[4];
        nie[i] = pwdata[2]; ncs[i] = int'(pwdata[1:0]);
      end
      if (w && rg == 1) ntdr[i] = int'(pwdata);
      novf[i] = (m_ovf[i] && !(w && rg == 3 && pwdata[0])) || so;
      nudf[i] = (m_udf[i] && !(w && rg == 3 && pwdata[1])) || su;
    end
    @(posedge pclk);
    if (rst) begin
      for (int i = 0; i < C; i++) begin
        m_cnt[i] = 0; m_tdr[i] = 0; m_cs[i] = 0; m_ar[i] = 0; m_dn[i] = 0;
        m_en[i] = 0; m_ie[i] = 0; m_ovf[i] = 0; m_udf[i] = 0;
      end
      n_edges = 0;
    end else begin
      m_cnt = ncnt; m_tdr = ntdr; m_cs = ncs; m_ar = nar; m_dn = ndn;
      m_en = nen; m_ie = nie; m_ovf = novf; m_udf = nudf;
      n_edges++;
    end
    #1;
    for (int i = 0; i < C; i++) begin
      chk("tmr_ovf", tmr_ovf[i], m_ovf[i]);
      chk("tmr_udf", tmr_udf[i], m_udf[i]);
    end
    chk("irq", irq, m_irq());
  endtask

  task automatic idle(input int n);
    for (int k = 0; k < n; k++) step();
  endtask

  task automatic apb(input bit wr, input int ch, input int rg, input int d);
    bit exp_err;
    psel = 1; penable = 0; pwrite = wr;
    paddr = AW'((ch << 2) | rg); pwdata = W'(d);
    step();
    penable = 1;
    #1;
    exp_err = (ch >= C) || (wr && rg == 2);
    chk("pready", pready, 1);
    chk("pslverr", pslverr, exp_err);
    if (!wr) chk("prdata", prdata, exp_err ? 0 : mread(ch, rg));
    step();
    psel = 0; penable = 0; pwrite = 0;
  endtask

  initial begin
    preset = 1; psel = 0; penable = 0; pwrite = 0; paddr = '0; pwdata = '0;
    n_edges = 0;
    for (int i = 0; i < C; i++) begin
      m_cnt[i] = 0; m_tdr[i] = 0; m_cs[i] = 0; m_ar[i] = 0; m_dn[i] = 0;
      m_en[i] = 0; m_ie[i] = 0; m_ovf[i] = 0; m_udf[i] = 0;
    end
    idle(2);
    preset = 0;

    // Reset defaults: every register of both channels reads 0.
    for (int c = 0; c < C; c++)
      for (int r = 0; r < 4; r++) apb(0, c, r, 0);

    // Up count with wrap on channel 0, then W1C of ovf.
    apb(1, 0, 1, 'hF0);
    apb(1, 0, 0, 'h80);
    apb(1, 0, 0, 'h10);
    idle(32);
    apb(0, 0, 2, 0);
    chk("ovf_after_wrap", tmr_ovf[0], 1);
    apb(1, 0, 3, 'h01);
    apb(0, 0, 3, 0);

    // Down count with auto-reload and interrupt on channel 1.
    apb(1, 1, 1, 'h03);
    apb(1, 1, 0, 'h80);
    apb(1, 1, 0, 'h74);
    for (int k = 0; k < 10; k++) apb(0, 1, 2, 0);
    chk("udf_irq", irq, 1);
    apb(1, 1, 0, 'h00);
    apb(1, 1, 3, 'h03);

    // Pause and resume channel 0 on clksel 1.
    apb(1, 0, 0, 'h11);
    idle(40);
    apb(1, 0, 0, 'h00);
    apb(0, 0, 2, 0);
    idle(40);
    apb(0, 0, 2, 0);
    apb(1, 0, 0, 'h11);
    idle(12);
    apb(0, 0, 2, 0);

    // Error responses: TCNT write and out-of-range channel.
    apb(1, 0, 2, 'h5A);
    apb(0, 0, 2, 0);
    apb(0, 2, 1, 0);
    apb(1, 2, 1, 'h33);
    apb(0, 3, 0, 0);

    // Wrap and W1C of ovf on the same edge: the set wins.
    apb(1, 0, 0, 'h00);
    apb(1, 0, 1, 'hFF);
    apb(1, 0, 0, 'h80);
    apb(1, 0, 3, 'h03);
    apb(1, 0, 0, 'h17);
    while ((n_edges % 16) != 14) step();
    apb(1, 0, 3, 'h01);
    chk("set_beats_w1c", tmr_ovf[0], 1);

    // Load on a tick edge: cnt takes TDR rather than counting.
    apb(1, 1, 1, 'h55);
    apb(1, 1, 0, 'h10);
    while ((n_edges % 2) != 0) step();
    apb(1, 1, 0, 'h90);
    apb(0, 1, 2, 0);

    // Random traffic, including resets in the middle of a transfer.
    for (int n = 0; n < 400; n++) begin
      int r = $urandom_range(0, 99);
      int ch = ($urandom_range(0, 9) == 0) ? 2 + $urandom_range(0, 1) : $urandom_range(0, 1);
      if (r < 2) begin
        psel = 1; penable = 0; pwrite = 1; paddr = AW'(ch << 2); pwdata = W'($urandom);
        step();
        penable = 1; preset = 1;
        step();
        preset = 0; psel = 0; penable = 0; pwrite = 0;
      end else begin
        apb(1'($urandom_range(0, 1)), ch, $urandom_range(0, 3), int'($urandom_range(0, 255)));
      end
      idle($urandom_range(0, 5));
    end

    for (int c = 0; c < C; c++)
      for (int r = 0; r < 4; r++) apb(0, c, r, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
`default_nettype wire
